prewish5k_mask_arbiter: RTL and testbench
=========================================

// Module: prewish5k_mask_arbiter
// PURPOSE
//  Round-robin arbiter sharing the mentor's mask input (STB_I/DAT_I) among N mask sources
//  (button/DIP loader, auto-advance timer, future UART loader).
//  Grants one requester at a time and issues a one-cycle strobe plus an 8-bit mask to the mentor.
//  Acks the winner in the same cycle, then enforces a holdoff gap so the blinky can restart cleanly.
// PARAMETERS
//  NUM_REQ      2   number of requesters, 2..4
//  GAP_CYCLES   16  holdoff cycles after each strobe, 0..255; 0 = no holdoff state
//  ALIVE_BITS   22  width of the alive counter; o_alive = its MSB
// PORTS
//  CLK_I    in   1          system clock
//  RST_I    in   1          synchronous, active-high reset
//  i_req    in   NUM_REQ    level request, one bit per requester; held until acked
//  i_dat    in   8*NUM_REQ  mask of requester k at bits [8k+7:8k]; stable while i_req[k]=1
//  o_ack    out  NUM_REQ    one-cycle pulse to the granted requester
//  STB_O    out  1          one-cycle strobe to mentor STB_I
//  DAT_O    out  8          mask to mentor DAT_I; valid while STB_O=1, holds last value otherwise
//  o_busy   out  1          1 in any state other than IDLE
//  o_alive  out  1          heartbeat for a board LED
// BEHAVIOUR
//  Reset: state=IDLE, STB_O=0, DAT_O=0, o_ack=0, o_busy=0, rr pointer=NUM_REQ-1
//   (so requester 0 wins first), holdoff counter=0, alive counter=0.
//  All outputs are registered. Reset mid-operation aborts any pending strobe or ack on the next edge.
//  IDLE
//   - If i_req != 0, pick the first set bit searching from (ptr+1) mod NUM_REQ upward with wrap.
//   - On that edge: latch DAT_O from that slice, set STB_O=1 and o_ack[win]=1, ptr<=win, go STROBE.
//   - If i_req == 0, stay in IDLE.
//  STROBE (exactly 1 cycle)
//   - STB_O and o_ack are high during this cycle.
//   - On exit they clear to 0.
//   - Next state: HOLD with cnt=GAP_CYCLES-1 if GAP_CYCLES>0, else IDLE.
//  HOLD
//   - Decrement cnt each cycle; go to IDLE when cnt==0.
//   - Requests are ignored but not lost: level requests persist.
//  Latency: request seen in IDLE at edge t -> STB_O/o_ack high in cycle t+1.
//  Strobe spacing: minimum strobe-to-strobe spacing is GAP_CYCLES+2 cycles.
//  Ack rule: the requester must drop i_req on the cycle after o_ack.
//   - A request still high after HOLD is treated as a new request.
//  Fairness: simultaneous requests are served in rotation. With all bits held high the grant
//   order is 0,1,..,NUM_REQ-1,0,..; a lone requester wins every time.
//  A request that rises during STROBE or HOLD waits; the rr pointer alone decides the order.
//  Widths: the holdoff counter is 8 bits and GAP_CYCLES is truncated to 8 bits.
//   The alive counter free-runs and wraps; it is cleared only by reset.
// CONFIGURATION
//  Macro PREWISH5K_ARB_DEDUP_EN:
//   - Defined: a winner whose mask equals the last strobed mask gets o_ack=1 in the STROBE cycle
//     with STB_O=0, DAT_O unchanged, and goes straight to IDLE (no HOLD).
//   - "Last strobed mask" is invalid after reset, so the first request always strobes.
//  Undefined: every grant strobes, including repeats of the same mask.
// STRUCTURE
//  prewish5k_pkg holds:
//   - MASK_W=8
//   - state encodings ARB_IDLE=2'b00, ARB_STROBE=2'b01, ARB_HOLD=2'b11
//   - GAP_W=8
//  Sub-module prewish5k_rr_picker: purely combinational, (req, ptr) -> (any, win index);
//   one-hot rotate plus priority encode.
//  Top level holds the FSM, data mux/latch, holdoff counter, dedup register and alive counter.
// TESTING
//  T1 reset:
//   - Hold RST_I for 3 cycles with i_req=2'b11.
//   - Expect STB_O=0, o_ack=0 throughout.
//   - Release; first STB_O 1 cycle after release with DAT_O=i_dat[7:0].
//  T2 single request:
//   - GAP=16; req0 with mask 8'hA5.
//   - Expect STB_O=1 and o_ack=2'b01 for exactly 1 cycle, DAT_O=8'hA5.
//   - Expect o_busy high for 17 cycles.
//  T3 fairness:
//   - NUM_REQ=3, all requests held high, masks 8'h11/8'h22/8'h33, GAP=4.
//   - Expect strobe sequence 11,22,33,11 spaced 6 cycles apart.
//  T4 contention in HOLD:
//   - req1 rises 2 cycles into HOLD after a req0 grant.
//   - Expect req1 granted on the first IDLE cycle after HOLD ends, not earlier.
//  T5 reset mid-STROBE:
//   - Assert RST_I in the STROBE cycle.
//   - Expect STB_O=0, o_ack=0, state IDLE next edge; pointer back to NUM_REQ-1.
//  T6 dedup (PREWISH5K_ARB_DEDUP_EN):
//   - Send mask 8'h3C twice via req0.
//   - Expect 1st: STB_O pulse. 2nd: o_ack pulse with STB_O=0, no HOLD.
//   - Without the macro, expect 2 strobes.

Source files
------------

// File: rtl/prewish5k_pkg.sv
// prewish5k_pkg: shared widths, arbiter state encodings and a small index-width helper
// for the mask arbiter slice.
package prewish5k_pkg;

   localparam int MASK_W = 8;
   localparam int GAP_W  = 8;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'b00,
      ARB_STROBE = 2'b01,
      ARB_HOLD   = 2'b11
   } arb_state_t;

   // Width of a requester index; a single requester still gets one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/prewish5k_rr_picker.sv
// prewish5k_rr_picker: combinational round-robin pick. The request vector is rotated so the
// requester just after the pointer sits at bit 0, then the lowest set bit wins.
module prewish5k_rr_picker
   import prewish5k_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = idx_w(NUM_REQ)
)
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               req_any,
   output logic [IDX_W-1:0]   win_idx
);

   logic [NUM_REQ-1:0] rotated;
   logic               found;
   int                 src;

   assign req_any = |req;

   // Rotate requests so that position 0 is the requester after the last winner.
   always_comb begin
      rotated = '0;
      src     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         src        = (int'(ptr) + 1 + i) % NUM_REQ;
         rotated[i] = req[src[IDX_W-1:0]];
      end
   end

   // Priority-encode the rotated vector and map the position back to a requester index.
   always_comb begin
      win_idx = '0;
      found   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && rotated[i]) begin
            win_idx = IDX_W'((int'(ptr) + 1 + i) % NUM_REQ);
            found   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/prewish5k_mask_arbiter.sv
// prewish5k_mask_arbiter: round-robin arbiter sharing the mentor's mask input among several
// mask sources. One grant produces a one-cycle strobe plus ack, followed by a holdoff gap.
// Optional macro PREWISH5K_ARB_DEDUP_EN: a grant repeating the last strobed mask is acked
// without strobing and skips the holdoff.
module prewish5k_mask_arbiter
   import prewish5k_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int GAP_CYCLES = 16,
   parameter int ALIVE_BITS = 22
)
(
   input  logic                      CLK_I,
   input  logic                      RST_I,
   input  logic [NUM_REQ-1:0]        i_req,
   input  logic [MASK_W*NUM_REQ-1:0] i_dat,
   output logic [NUM_REQ-1:0]        o_ack,
   output logic                      STB_O,
   output logic [MASK_W-1:0]         DAT_O,
   output logic                      o_busy,
   output logic                      o_alive
);

   localparam int                 IDX_W   = idx_w(NUM_REQ);
   localparam logic [GAP_W-1:0]   GAP_VAL = GAP_W'(GAP_CYCLES);
   localparam logic [IDX_W-1:0]   PTR_RST = IDX_W'(NUM_REQ - 1);

   arb_state_t              state;
   arb_state_t              state_next;
   logic [IDX_W-1:0]        ptr;
   logic [IDX_W-1:0]        ptr_next;
   logic [GAP_W-1:0]        cnt;
   logic [GAP_W-1:0]        cnt_next;
   logic                    stb_next;
   logic [NUM_REQ-1:0]      ack_next;
   logic [MASK_W-1:0]       dat_next;
   logic                    dup_r;
   logic                    dup_next;
   logic                    is_dup;
   logic                    req_any;
   logic [IDX_W-1:0]        req_win;
   logic [MASK_W-1:0]       win_mask;
   logic [MASK_W-1:0]       slice [NUM_REQ];
   logic [ALIVE_BITS-1:0]   alive_cnt;

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
      assign slice[k] = i_dat[k*MASK_W +: MASK_W];
   end

   assign win_mask = slice[req_win];

   prewish5k_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req     (i_req),
      .ptr     (ptr),
      .req_any (req_any),
      .win_idx (req_win)
   );

`ifdef PREWISH5K_ARB_DEDUP_EN
   logic last_valid;

   assign is_dup = last_valid && (win_mask == DAT_O);

   // DAT_O only ever changes on a real strobe, so it doubles as the last strobed mask;
   // this flag marks it meaningful once the first strobe after reset has gone out.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         last_valid <= 1'b0;
      end else if (stb_next) begin
         last_valid <= 1'b1;
      end
   end
`else
   assign is_dup = 1'b0;
`endif

   // State register.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: grant from IDLE, a single STROBE cycle, then optional holdoff.
   always_comb begin
      state_next = state;
      case (state)
         ARB_IDLE: begin
            if (req_any) begin
               state_next = ARB_STROBE;
            end
         end
         ARB_STROBE: begin
            if (dup_r || (GAP_VAL == '0)) begin
               state_next = ARB_IDLE;
            end else begin
               state_next = ARB_HOLD;
            end
         end
         ARB_HOLD: begin
            if (cnt == '0) begin
               state_next = ARB_IDLE;
            end
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   // Output logic: next values for the registered strobe, ack, mask, pointer and holdoff count.
   always_comb begin
      stb_next = 1'b0;
      ack_next = '0;
      dat_next = DAT_O;
      ptr_next = ptr;
      cnt_next = cnt;
      dup_next = dup_r;
      case (state)
         ARB_IDLE: begin
            if (req_any) begin
               ack_next[req_win] = 1'b1;
               stb_next          = !is_dup;
               dat_next          = is_dup ? DAT_O : win_mask;
               ptr_next          = req_win;
               dup_next          = is_dup;
            end
         end
         ARB_STROBE: begin
            cnt_next = GAP_VAL - GAP_W'(1);
            dup_next = 1'b0;
         end
         ARB_HOLD: begin
            if (cnt != '0) begin
               cnt_next = cnt - GAP_W'(1);
            end
         end
         default: begin
            dup_next = 1'b0;
         end
      endcase
   end

   // Registered outputs and datapath; reset aborts any strobe or ack in flight.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         STB_O  <= 1'b0;
         o_ack  <= '0;
         DAT_O  <= '0;
         o_busy <= 1'b0;
         ptr    <= PTR_RST;
         cnt    <= '0;
         dup_r  <= 1'b0;
      end else begin
         STB_O  <= stb_next;
         o_ack  <= ack_next;
         DAT_O  <= dat_next;
         o_busy <= (state_next != ARB_IDLE);
         ptr    <= ptr_next;
         cnt    <= cnt_next;
         dup_r  <= dup_next;
      end
   end

   // Free-running heartbeat counter; its MSB blinks the board LED.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         alive_cnt <= '0;
      end else begin
         alive_cnt <= alive_cnt + ALIVE_BITS'(1);
      end
   end

   assign o_alive = alive_cnt[ALIVE_BITS-1];

endmodule

// File: tb/tb_prewish5k_mask_arbiter.sv
// tb_prewish5k_mask_arbiter: directed bench for the mask arbiter. dut_a is a 2-requester,
// 16-cycle-gap instance with a short heartbeat counter; dut_b is a 3-requester, 4-cycle-gap
// instance used for rotation and mid-strobe reset. Inputs change and outputs are sampled
// on the falling clock edge. Honours PREWISH5K_ARB_DEDUP_EN for the repeat-mask scenario.
module tb_prewish5k_mask_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  req_a;
   logic [15:0] dat_a;
   logic [1:0]  ack_a;
   logic        stb_a;
   logic [7:0]  dato_a;
   logic        busy_a;
   logic        alive_a;
   logic [2:0]  req_b;
   logic [23:0] dat_b;
   logic [2:0]  ack_b;
   logic        stb_b;
   logic [7:0]  dato_b;
   logic        busy_b;
   logic        alive_b;

   int checks = 0;
   int errors = 0;

   prewish5k_mask_arbiter #(
      .NUM_REQ    (2),
      .GAP_CYCLES (16),
      .ALIVE_BITS (4)
   ) dut_a (
      .CLK_I   (clk),
      .RST_I   (rst),
      .i_req   (req_a),
      .i_dat   (dat_a),
      .o_ack   (ack_a),
      .STB_O   (stb_a),
      .DAT_O   (dato_a),
      .o_busy  (busy_a),
      .o_alive (alive_a)
   );

   prewish5k_mask_arbiter #(
      .NUM_REQ    (3),
      .GAP_CYCLES (4),
      .ALIVE_BITS (22)
   ) dut_b (
      .CLK_I   (clk),
      .RST_I   (rst),
      .i_req   (req_b),
      .i_dat   (dat_b),
      .o_ack   (ack_b),
      .STB_O   (stb_b),
      .DAT_O   (dato_b),
      .o_busy  (busy_b),
      .o_alive (alive_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Waits (bounded) until dut_a reports idle, returning on that falling edge.
   task automatic wait_idle_a();
      bit done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (!busy_a) done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("[TB] FAIL idle_a timeout: busy=%b required 0 within 40 cycles", busy_a);
      end
   endtask

   // Waits (bounded) until dut_b reports idle, returning on that falling edge.
   task automatic wait_idle_b();
      bit done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (!busy_b) done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("[TB] FAIL idle_b timeout: busy=%b required 0 within 40 cycles", busy_b);
      end
   endtask

   // Reset held with both requests up, then first grant goes to requester 0; heartbeat MSB.
   task automatic test_reset();
      rst   = 1'b1;
      req_a = 2'b11;
      dat_a = {8'h5A, 8'hC3};
      req_b = '0;
      dat_b = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (stb_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_stb cycle %0d: got %b required 0", i, stb_a);
         end
         checks++;
         if (ack_a !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_ack cycle %0d: got %b required 00", i, ack_a);
         end
         checks++;
         if (busy_a !== 1'b0 || dato_a !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_busy_dat cycle %0d: got busy=%b dat=%h required 0/00", i, busy_a, dato_a);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (stb_a !== 1'b1 || ack_a !== 2'b01 || dato_a !== 8'hC3) begin
         errors++;
         $display("[TB] FAIL reset_first_grant: got stb=%b ack=%b dat=%h required 1/01/c3", stb_a, ack_a, dato_a);
      end
      checks++;
      if (alive_a !== 1'b0) begin
         errors++;
         $display("[TB] FAIL alive_low: got %b required 0", alive_a);
      end
      req_a = 2'b00;
      repeat (6) @(negedge clk);
      checks++;
      if (alive_a !== 1'b0) begin
         errors++;
         $display("[TB] FAIL alive_count7: got %b required 0", alive_a);
      end
      @(negedge clk);
      checks++;
      if (alive_a !== 1'b1) begin
         errors++;
         $display("[TB] FAIL alive_count8: got %b required 1", alive_a);
      end
   endtask

   // Lone request: one-cycle strobe/ack with its mask, busy for strobe plus 16 holdoff cycles.
   task automatic test_single_request();
      int busy_cycles;
      int extra_strobes;
      wait_idle_a();
      req_a = 2'b01;
      dat_a = {8'h00, 8'hA5};
      @(negedge clk);
      checks++;
      if (stb_a !== 1'b1 || ack_a !== 2'b01 || dato_a !== 8'hA5 || busy_a !== 1'b1) begin
         errors++;
         $display("[TB] FAIL single_grant: got stb=%b ack=%b dat=%h busy=%b required 1/01/a5/1", stb_a, ack_a, dato_a, busy_a);
      end
      req_a = 2'b00;
      busy_cycles   = 1;
      extra_strobes = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy_a) break;
         busy_cycles++;
         if (stb_a || ack_a != 2'b00) extra_strobes++;
      end
      checks++;
      if (busy_cycles != 17) begin
         errors++;
         $display("[TB] FAIL single_busy_len: got %0d cycles required 17", busy_cycles);
      end
      checks++;
      if (extra_strobes != 0) begin
         errors++;
         $display("[TB] FAIL single_one_pulse: got %0d extra strobe/ack cycles required 0", extra_strobes);
      end
      checks++;
      if (dato_a !== 8'hA5) begin
         errors++;
         $display("[TB] FAIL single_dat_hold: got %h required a5", dato_a);
      end
   endtask

   // Three requesters held high: rotation 11,22,33,11 with 6-cycle spacing.
   task automatic test_fairness();
      logic [7:0] exp_mask [4];
      logic [2:0] exp_ack [4];
      logic [7:0] got_mask [4];
      logic [2:0] got_ack [4];
      int         got_cyc [4];
      int         n;
      exp_mask[0] = 8'h11; exp_mask[1] = 8'h22; exp_mask[2] = 8'h33; exp_mask[3] = 8'h11;
      exp_ack[0]  = 3'b001; exp_ack[1] = 3'b010; exp_ack[2]  = 3'b100; exp_ack[3]  = 3'b001;
      n = 0;
      wait_idle_b();
      req_b = 3'b111;
      dat_b = {8'h33, 8'h22, 8'h11};
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (stb_b) begin
            if (n < 4) begin
               got_mask[n] = dato_b;
               got_ack[n]  = ack_b;
               got_cyc[n]  = i;
            end
            n++;
         end
      end
      req_b = 3'b000;
      checks++;
      if (n != 4) begin
         errors++;
         $display("[TB] FAIL fair_count: got %0d strobes required 4", n);
      end
      for (int k = 0; k < 4 && k < n; k++) begin
         checks++;
         if (got_mask[k] !== exp_mask[k] || got_ack[k] !== exp_ack[k]) begin
            errors++;
            $display("[TB] FAIL fair_order %0d: got dat=%h ack=%b required %h/%b", k, got_mask[k], got_ack[k], exp_mask[k], exp_ack[k]);
         end
         checks++;
         if (got_cyc[k] != 1 + 6 * k) begin
            errors++;
            $display("[TB] FAIL fair_spacing %0d: got cycle %0d required %0d", k, got_cyc[k], 1 + 6 * k);
         end
      end
   endtask

   // Request rising inside HOLD waits until the first IDLE cycle after the gap.
   task automatic test_contention();
      int early;
      wait_idle_a();
      req_a = 2'b01;
      dat_a = {8'h99, 8'h42};
      @(negedge clk);
      checks++;
      if (stb_a !== 1'b1 || ack_a !== 2'b01 || dato_a !== 8'h42) begin
         errors++;
         $display("[TB] FAIL hold_first_grant: got stb=%b ack=%b dat=%h required 1/01/42", stb_a, ack_a, dato_a);
      end
      req_a = 2'b00;
      @(negedge clk);
      @(negedge clk);
      req_a = 2'b10;
      early = 0;
      for (int i = 4; i <= 19; i++) begin
         @(negedge clk);
         if (i < 19) begin
            if (stb_a !== 1'b0 || ack_a !== 2'b00) early++;
         end else begin
            checks++;
            if (stb_a !== 1'b1 || ack_a !== 2'b10 || dato_a !== 8'h99) begin
               errors++;
               $display("[TB] FAIL hold_late_grant: got stb=%b ack=%b dat=%h required 1/10/99", stb_a, ack_a, dato_a);
            end
         end
      end
      checks++;
      if (early != 0) begin
         errors++;
         $display("[TB] FAIL hold_no_early: got %0d early grant cycles required 0", early);
      end
      req_a = 2'b00;
   endtask

   // Reset during STROBE clears outputs next edge and sends the pointer back to the top.
   task automatic test_reset_mid_strobe();
      wait_idle_b();
      req_b = 3'b010;
      dat_b = {8'h33, 8'h22, 8'h11};
      @(negedge clk);
      checks++;
      if (stb_b !== 1'b1 || ack_b !== 3'b010 || dato_b !== 8'h22) begin
         errors++;
         $display("[TB] FAIL midrst_pre: got stb=%b ack=%b dat=%h required 1/010/22", stb_b, ack_b, dato_b);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (stb_b !== 1'b0 || ack_b !== 3'b000 || busy_b !== 1'b0 || dato_b !== 8'h00) begin
         errors++;
         $display("[TB] FAIL midrst_clear: got stb=%b ack=%b busy=%b dat=%h required 0/000/0/00", stb_b, ack_b, busy_b, dato_b);
      end
      rst   = 1'b0;
      req_b = 3'b111;
      @(negedge clk);
      checks++;
      if (stb_b !== 1'b1 || ack_b !== 3'b001 || dato_b !== 8'h11) begin
         errors++;
         $display("[TB] FAIL midrst_ptr: got stb=%b ack=%b dat=%h required 1/001/11", stb_b, ack_b, dato_b);
      end
      req_b = 3'b000;
   endtask

   // Same mask sent twice through requester 0.
   task automatic test_dedup();
      wait_idle_a();
      req_a = 2'b01;
      dat_a = {8'h00, 8'h3C};
      @(negedge clk);
      checks++;
      if (stb_a !== 1'b1 || ack_a !== 2'b01 || dato_a !== 8'h3C) begin
         errors++;
         $display("[TB] FAIL dedup_first: got stb=%b ack=%b dat=%h required 1/01/3c", stb_a, ack_a, dato_a);
      end
      req_a = 2'b00;
      wait_idle_a();
      req_a = 2'b01;
      @(negedge clk);
`ifdef PREWISH5K_ARB_DEDUP_EN
      checks++;
      if (stb_a !== 1'b0 || ack_a !== 2'b01 || dato_a !== 8'h3C) begin
         errors++;
         $display("[TB] FAIL dedup_second: got stb=%b ack=%b dat=%h required 0/01/3c", stb_a, ack_a, dato_a);
      end
      req_a = 2'b00;
      @(negedge clk);
      checks++;
      if (busy_a !== 1'b0) begin
         errors++;
         $display("[TB] FAIL dedup_no_hold: got busy=%b required 0", busy_a);
      end
`else
      checks++;
      if (stb_a !== 1'b1 || ack_a !== 2'b01 || dato_a !== 8'h3C) begin
         errors++;
         $display("[TB] FAIL repeat_second: got stb=%b ack=%b dat=%h required 1/01/3c", stb_a, ack_a, dato_a);
      end
      req_a = 2'b00;
      @(negedge clk);
      checks++;
      if (busy_a !== 1'b1 || stb_a !== 1'b0) begin
         errors++;
         $display("[TB] FAIL repeat_hold: got busy=%b stb=%b required 1/0", busy_a, stb_a);
      end
`endif
      wait_idle_a();
   endtask

   // Runs the scenarios in order and prints the summary.
   initial begin
      rst   = 1'b1;
      req_a = '0;
      dat_a = '0;
      req_b = '0;
      dat_b = '0;
      test_reset();
      test_single_request();
      test_fairness();
      test_contention();
      test_reset_mid_strobe();
      test_dedup();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time exceeded 200000 required completion earlier");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
